// File: rtl/lut_delay_pkg.sv
// Shared definitions for the LUT delay-line tap calibration block.
//   cal_state_t : calibration FSM states
//   win_centre  : floor centre of a tap window given its first tap and length
//   DEF_*       : default delay-line geometry
package lut_delay_pkg;

    localparam int DEF_N_TAPS = 32;
    localparam int DEF_TAP_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        EVAL,
        DONE
    } cal_state_t;

    // Caller guarantees len >= 1; result is first + floor((len-1)/2).
    function automatic int unsigned win_centre(input int unsigned first,
                                               input int unsigned len);
        return first + ((len - 1) >> 1);
    endfunction

endpackage

// File: rtl/lut_tap_window_tracker.sv
// Tracks the current run of passing taps and the best (longest) run seen so
// far during a calibration sweep.
//   clk_i, rst_n_i : clock, async active-low reset
//   clear_i        : zero all window state (start of a sweep)
//   eval_i         : one tap's verdict is available this cycle
//   pass_i         : verdict for tap_i (1 = pass), qualified by eval_i
//   tap_i          : tap being evaluated
//   best_first_o   : first tap of the best window
//   best_len_o     : length of the best window (0 = none passed)
module lut_tap_window_tracker #(
    parameter int TAP_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             eval_i,
    input  logic             pass_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [TAP_W-1:0] best_first_o,
    output logic [TAP_W:0]   best_len_o
);

    logic [TAP_W-1:0] cur_first_q, cur_first_d;
    logic [TAP_W:0]   cur_len_q,   cur_len_d;
    logic [TAP_W-1:0] best_first_q, best_first_d;
    logic [TAP_W:0]   best_len_q,   best_len_d;
    logic [TAP_W-1:0] run_first;
    logic [TAP_W:0]   run_len;

    always_comb begin
        cur_first_d  = cur_first_q;
        cur_len_d    = cur_len_q;
        best_first_d = best_first_q;
        best_len_d   = best_len_q;
        // A passing tap either opens a new run or extends the current one.
        run_first    = (cur_len_q == '0) ? tap_i : cur_first_q;
        run_len      = cur_len_q + (TAP_W+1)'(1);

        if (clear_i) begin
            cur_first_d  = '0;
            cur_len_d    = '0;
            best_first_d = '0;
            best_len_d   = '0;
        end else if (eval_i) begin
            if (pass_i) begin
                cur_first_d = run_first;
                cur_len_d   = run_len;
                // Strictly greater: on a tie the earlier window is kept.
                if (run_len > best_len_q) begin
                    best_first_d = run_first;
                    best_len_d   = run_len;
                end
            end else begin
                cur_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur_first_q  <= '0;
            cur_len_q    <= '0;
            best_first_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_first_q  <= cur_first_d;
            cur_len_q    <= cur_len_d;
            best_first_q <= best_first_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_first_o = best_first_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/lut_delay_tap_cal.sv
// Tap calibration controller for a LUT-buffer delay line. Sweeps every tap,
// qualifies each with SAMPLE_CYC cycles of match_i after SETTLE_CYC cycles of
// settling, then parks tap_o at the centre of the widest passing window.
// Outside a sweep, software can force the tap via manual_en_i/manual_tap_i.
//   clk_i, rst_n_i  : clock, async active-low reset
//   start_i         : calibration request (sampled in IDLE)
//   abort_i         : abandon a running sweep, restore the pre-sweep tap
//   manual_en_i     : in IDLE, tap_o follows saturated manual_tap_i
//   manual_tap_i    : manual tap value
//   match_i         : datapath compare result, 1 = pass
//   tap_o           : delay-line tap select
//   busy_o          : sweep in progress
//   done_o          : one-cycle pulse at sweep end
//   fail_o          : no tap passed (held until next start)
//   win_first_o     : first tap of best window
//   win_len_o       : length of best window
module lut_delay_tap_cal
    import lut_delay_pkg::*;
#(
    parameter int N_TAPS     = DEF_N_TAPS,
    parameter int TAP_W      = DEF_TAP_W,
    parameter int SETTLE_CYC = 8,
    parameter int SAMPLE_CYC = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             manual_en_i,
    input  logic [TAP_W-1:0] manual_tap_i,
    input  logic             match_i,
    output logic [TAP_W-1:0] tap_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [TAP_W-1:0] win_first_o,
    output logic [TAP_W:0]   win_len_o
);

    localparam logic [TAP_W:0]   N_TAPS_L   = (TAP_W+1)'(N_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(N_TAPS - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_END = CNT_W'(SAMPLE_CYC - 1);

    cal_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] saved_tap_q, saved_tap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [TAP_W-1:0] win_first_q, win_first_d;
    logic [TAP_W:0]   win_len_q, win_len_d;
    logic             err_q, err_d;

    logic             trk_clear, trk_eval;
    logic [TAP_W-1:0] best_first;
    logic [TAP_W:0]   best_len;
    logic [TAP_W-1:0] manual_sat;

    // TAP_W may address more taps than exist; clamp to the last real tap.
    always_comb begin
        if ({1'b0, manual_tap_i} >= N_TAPS_L) manual_sat = LAST_TAP;
        else                                  manual_sat = manual_tap_i;
    end

    lut_tap_window_tracker #(
        .TAP_W (TAP_W)
    ) u_tracker (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clear_i      (trk_clear),
        .eval_i       (trk_eval),
        .pass_i       (!err_q),
        .tap_i        (tap_q),
        .best_first_o (best_first),
        .best_len_o   (best_len)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tap_d       = tap_q;
        saved_tap_d = saved_tap_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fail_d      = fail_q;
        win_first_d = win_first_q;
        win_len_d   = win_len_q;
        err_d       = err_q;
        trk_clear   = 1'b0;
        trk_eval    = 1'b0;

        if (abort_i && (state_q == SETTLE || state_q == SAMPLE || state_q == EVAL)) begin
            state_d = IDLE;
            tap_d   = saved_tap_q;
            busy_d  = 1'b0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        saved_tap_d = tap_q;
                        tap_d       = '0;
                        trk_clear   = 1'b1;
                        fail_d      = 1'b0;
                        busy_d      = 1'b1;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                        state_d     = SETTLE;
                    end else if (manual_en_i) begin
                        tap_d = manual_sat;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_END) begin
                        cnt_d   = '0;
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    // err_q absorbs the last sample on the exit edge, so EVAL
                    // sees the full window.
                    err_d = err_q | ~match_i;
                    if (cnt_q == SAMPLE_END) begin
                        cnt_d   = '0;
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                EVAL: begin
                    trk_eval = 1'b1;
                    err_d    = 1'b0;
                    if (tap_q == LAST_TAP) begin
                        state_d = DONE;
                    end else begin
                        tap_d   = tap_q + TAP_W'(1);
                        state_d = SETTLE;
                    end
                end
                DONE: begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    win_first_d = best_first;
                    win_len_d   = best_len;
                    if (best_len == '0) begin
                        fail_d = 1'b1;
                        tap_d  = saved_tap_q;
                    end else begin
                        tap_d = TAP_W'(win_centre(32'(best_first), 32'(best_len)));
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tap_q       <= '0;
            saved_tap_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            win_first_q <= '0;
            win_len_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tap_q       <= tap_d;
            saved_tap_q <= saved_tap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            win_first_q <= win_first_d;
            win_len_q   <= win_len_d;
            err_q       <= err_d;
        end
    end

    assign tap_o       = tap_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign win_first_o = win_first_q;
    assign win_len_o   = win_len_q;

endmodule

// File: tb/tb_lut_delay_tap_cal.sv
module tb_lut_delay_tap_cal;

    localparam int N   = 32;
    localparam int LAT = 1 + N * (8 + 64 + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (default geometry)
    logic        start = 1'b0, abort = 1'b0, man_en = 1'b0;
    logic [4:0]  man_tap = '0;
    logic [31:0] mask = '0;
    logic        glitch = 1'b0;
    logic        match;
    logic [4:0]  tap_o, wfirst;
    logic [5:0]  wlen;
    logic        busy, done, fail;

    assign match = mask[tap_o] & ~glitch;

    lut_delay_tap_cal dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .manual_en_i(man_en), .manual_tap_i(man_tap), .match_i(match),
        .tap_o(tap_o), .busy_o(busy), .done_o(done), .fail_o(fail),
        .win_first_o(wfirst), .win_len_o(wlen)
    );

    // small instance: non-power-of-two tap count, minimal settle/sample
    logic        start2 = 1'b0, abort2 = 1'b0, man_en2 = 1'b0, match2 = 1'b1;
    logic [4:0]  man_tap2 = '0;
    logic [4:0]  tap2, wf2;
    logic [5:0]  wl2;
    logic        busy2, done2, fail2;

    lut_delay_tap_cal #(.N_TAPS(20), .TAP_W(5), .SETTLE_CYC(1), .SAMPLE_CYC(1), .CNT_W(8)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .abort_i(abort2),
        .manual_en_i(man_en2), .manual_tap_i(man_tap2), .match_i(match2),
        .tap_o(tap2), .busy_o(busy2), .done_o(done2), .fail_o(fail2),
        .win_first_o(wf2), .win_len_o(wl2)
    );

    typedef struct {
        logic [31:0] mask;
        bit          man;
        int          man_tap;
        int          g_tap;   // tap receiving a one-cycle match dropout (-1 none)
        int          g_off;   // cycles after that tap is selected
        int          e_first;
        int          e_len;
        int          e_tap;
        int          e_fail;
    } vec_t;

    vec_t vecs[9];
    vec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cal(input vec_t v);
        int         cyc;
        int         since;
        logic [4:0] prev;
        bit         got;
        vec_t       e;
        mask = v.mask;
        exp_q.push_back(v);
        if (v.man) begin
            man_tap = 5'(v.man_tap);
            man_en  = 1'b1;
            tick();
            tick();
            chk("manual_tap", int'(tap_o), v.man_tap);
            man_en = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("tap_zero_after_start", int'(tap_o), 0);
        prev = tap_o;
        since = 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < LAT + 100) begin
            glitch = (v.g_tap >= 0 && int'(tap_o) == v.g_tap && since == v.g_off);
            tick();
            cyc++;
            if (tap_o != prev) begin
                since = 0;
                prev = tap_o;
            end else begin
                since++;
            end
            if (done) got = 1'b1;
        end
        glitch = 1'b0;
        e = exp_q.pop_front();
        if (!got) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("latency", cyc, LAT);
        chk("win_first", int'(wfirst), e.e_first);
        chk("win_len", int'(wlen), e.e_len);
        chk("tap_final", int'(tap_o), e.e_tap);
        chk("fail", int'(fail), e.e_fail);
        chk("busy_at_done", int'(busy), 0);
        tick();
        chk("done_one_cycle", int'(done), 0);
    endtask

    task automatic wait_tap(input int t, output bit found);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (int'(tap_o) == t) found = 1'b1;
        end
    endtask

    initial begin
        bit   found;
        int   seen;
        int   cyc;
        int   sat_in[5];
        int   sat_exp[5];

        //             mask           man  mt  gt  go first len tap fail
        vecs[0] = '{32'hFFFF_FFFF, 1'b0, 0, -1,  0,  0, 32, 15, 0};
        vecs[1] = '{32'h001F_FC00, 1'b0, 0, -1,  0, 10, 11, 15, 0};
        vecs[2] = '{32'h0FF0_0078, 1'b0, 0, -1,  0, 20,  8, 23, 0};
        vecs[3] = '{32'h0000_3C3C, 1'b0, 0, -1,  0,  2,  4,  3, 0};
        vecs[4] = '{32'h0000_0000, 1'b1, 7, -1,  0,  0,  0,  7, 1};
        vecs[5] = '{32'hFFFF_FFFF, 1'b0, 0,  9, 20, 10, 22, 20, 0};  // dropout in SAMPLE
        vecs[6] = '{32'hFFFF_FFFF, 1'b0, 0,  5,  3,  0, 32, 15, 0};  // dropout in SETTLE
        vecs[7] = '{32'h8000_0000, 1'b0, 0, -1,  0, 31,  1, 31, 0};
        vecs[8] = '{32'h0000_0001, 1'b0, 0, -1,  0,  0,  1,  0, 0};

        sat_in  = '{25, 19, 31, 12, 0};
        sat_exp = '{19, 19, 19, 12, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tap", int'(tap_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_wfirst", int'(wfirst), 0);
        chk("rst_wlen", int'(wlen), 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_cal(vecs[i]);

        // manual request ignored while busy
        mask = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        man_tap = 5'd30;
        man_en = 1'b1;
        repeat (3) tick();
        chk("manual_ignored_busy", int'(tap_o), 0);
        man_en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_restore_prev", int'(tap_o), 0);

        // abort during tap 12 with saved tap 4
        man_tap = 5'd4;
        man_en = 1'b1;
        tick();
        tick();
        man_en = 1'b0;
        chk("manual_4", int'(tap_o), 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_tap(12, found);
        chk("reach_tap12", int'(found), 1);
        repeat (20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_tap", int'(tap_o), 4);
        chk("abort_done", int'(done), 0);
        chk("abort_fail", int'(fail), 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done || busy) seen++;
        end
        chk("abort_quiet", seen, 0);

        // start and abort together in SAMPLE: abort wins
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_tap(3, found);
        chk("reach_tap3", int'(found), 1);
        repeat (15) tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("startabort_busy", int'(busy), 0);
        chk("startabort_tap", int'(tap_o), 4);
        chk("startabort_done", int'(done), 0);
        tick();
        chk("startabort_idle", int'(busy), 0);

        // asynchronous reset mid-sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (500) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_tap", int'(tap_o), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_fail", int'(fail), 0);
        chk("arst_wfirst", int'(wfirst), 0);
        chk("arst_wlen", int'(wlen), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // saturation of manual tap on the 20-tap instance
        man_en2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            man_tap2 = 5'(sat_in[i]);
            tick();
            chk("manual_sat", int'(tap2), sat_exp[i]);
        end
        man_en2 = 1'b0;
        man_tap2 = 5'd3;
        tick();
        chk("manual_hold", int'(tap2), 0);

        // short full-pass sweep on the 20-tap instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 200) begin
            tick();
            cyc++;
            if (done2) found = 1'b1;
        end
        chk("small_done_seen", int'(found), 1);
        chk("small_latency", cyc, 1 + 20 * 3);
        chk("small_wfirst", int'(wf2), 0);
        chk("small_wlen", int'(wl2), 20);
        chk("small_tap", int'(tap2), 9);
        chk("small_fail", int'(fail2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
